instruction_fetch_stage: RTL and testbench

Pipeline IF stage, directly upstream of instruction decode. Owns the program counter and drives the instruction-memory request/ready handshake. Applies ID-stage redirect (PCSel/BranchPC) and hazard stalls (Stall_PC/Stall_ID), and produces the IF/ID pipeline register (Instruction, PCPlusFour, Valid) that decode consumes.

---
 rtl/instruction_fetch_stage_if.sv | 22 ++
 rtl/instruction_fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/ready bus between the IF stage and its memory.
// The fetch stage drives the request side; the memory answers with ready/data.
interface instruction_fetch_stage_if;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ready;
  logic [31:0] IMem_Data;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ready,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ready,
    output IMem_Data
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Pipeline IF stage: owns the program counter, runs the instruction-memory
// request/ready handshake, applies ID redirects and hazard stalls, and drives
// the IF/ID pipeline register consumed by decode.
//
// Three states:
//   FETCH   - normal operation; a request may be outstanding.
//   HOLD    - a fetch completed while ID was stalled; the word waits in the
//             hold buffer until ID can take it.
//   DISCARD - a redirect arrived while a request was outstanding; the old
//             request is finished and its data thrown away before the PC
//             moves to the redirect target.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             PCSel,
  input  logic [31:0]                      BranchPC,
  input  logic                             Stall_PC,
  input  logic                             Stall_ID,
  instruction_fetch_stage_if.master        imem,
  output logic [31:0]                      Instruction,
  output logic [31:0]                      PCPlusFour,
  output logic                             IF_ID_Valid,
  output logic [31:0]                      PC_out
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  // Architectural and pipeline state
  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic        pending_r;       // a request was issued and has not yet seen Ready
  logic [31:0] redirect_pc_r;   // target to load once DISCARD completes
  logic [31:0] if_instr_r;
  logic [31:0] if_pc4_r;
  logic        if_valid_r;
  logic [31:0] hold_instr_r;
  logic [31:0] hold_pc4_r;
  logic        hold_valid_r;

  // Per-cycle decisions
  logic        req_s;
  logic        complete_s;
  logic        outstanding_s;
  logic        redirect_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] branch_aligned_s;

  // Request generation, handshake completion and redirect acceptance.
  always_comb begin
    req_s            = 1'b0;
    complete_s       = 1'b0;
    outstanding_s    = 1'b0;
    redirect_s       = 1'b0;
    pc_plus4_s       = pc_r + 32'd4;
    branch_aligned_s = BranchPC & ALIGN_MASK;

    if (!Reset) begin
      // Reset aborts any in-flight request without waiting for Ready.
      req_s = 1'b0;
    end else begin
      case (state_r)
        // Stall_PC only suppresses new requests; an outstanding one is kept.
        ST_FETCH:   req_s = pending_r | ~Stall_PC;
        ST_HOLD:    req_s = 1'b0;
        ST_DISCARD: req_s = 1'b1;
        default:    req_s = 1'b0;
      endcase
    end

    complete_s    = req_s & imem.IMem_Ready;
    outstanding_s = req_s & ~imem.IMem_Ready;
    // A redirect while ID is stalled is ignored; ID will present it again.
    redirect_s    = PCSel & if_valid_r & ~Stall_ID;
  end

  // PC, state machine, hold buffer and IF/ID register update.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC_ALIGNED;
      pending_r     <= 1'b0;
      redirect_pc_r <= 32'h0000_0000;
      if_instr_r    <= NOP_INSTR;
      if_pc4_r      <= 32'h0000_0000;
      if_valid_r    <= 1'b0;
      hold_instr_r  <= NOP_INSTR;
      hold_pc4_r    <= 32'h0000_0000;
      hold_valid_r  <= 1'b0;
    end else if (redirect_s) begin
      // Flush IF/ID and the hold buffer; any fetch completing now is dropped.
      if_instr_r   <= NOP_INSTR;
      if_valid_r   <= 1'b0;
      hold_valid_r <= 1'b0;
      if (outstanding_s) begin
        // The memory still owes us a word for the old address: finish it first.
        redirect_pc_r <= branch_aligned_s;
        pending_r     <= 1'b1;
        state_r       <= ST_DISCARD;
      end else begin
        pc_r      <= branch_aligned_s;
        pending_r <= 1'b0;
        state_r   <= ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (complete_s) begin
            pc_r      <= pc_plus4_s;
            pending_r <= 1'b0;
            if (Stall_ID) begin
              // ID cannot take the word yet: park it and stop fetching.
              hold_instr_r <= imem.IMem_Data;
              hold_pc4_r   <= pc_plus4_s;
              hold_valid_r <= 1'b1;
              state_r      <= ST_HOLD;
            end else begin
              if_instr_r <= imem.IMem_Data;
              if_pc4_r   <= pc_plus4_s;
              if_valid_r <= 1'b1;
            end
          end else begin
            pending_r <= outstanding_s;
            if (!Stall_ID) begin
              // Nothing arrived (memory wait or Stall_PC): insert a bubble.
              if_instr_r <= NOP_INSTR;
              if_valid_r <= 1'b0;
            end else begin
              if_valid_r <= if_valid_r;
            end
          end
        end

        ST_HOLD: begin
          pending_r <= 1'b0;
          if (!Stall_ID) begin
            if_instr_r   <= hold_instr_r;
            if_pc4_r     <= hold_pc4_r;
            if_valid_r   <= hold_valid_r;
            hold_valid_r <= 1'b0;
            state_r      <= ST_FETCH;
          end else begin
            state_r <= ST_HOLD;
          end
        end

        ST_DISCARD: begin
          if (complete_s) begin
            // Old word is thrown away; resume at the redirect target.
            pc_r      <= redirect_pc_r;
            pending_r <= 1'b0;
            state_r   <= ST_FETCH;
          end else begin
            pending_r <= 1'b1;
          end
          if (!Stall_ID) begin
            if_instr_r <= NOP_INSTR;
            if_valid_r <= 1'b0;
          end else begin
            if_valid_r <= if_valid_r;
          end
        end

        default: begin
          state_r   <= ST_FETCH;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // In DISCARD the PC has not moved yet, so it still names the outstanding address.
  assign imem.IMem_Req  = req_s;
  assign imem.IMem_Addr = pc_r & ALIGN_MASK;

  assign Instruction = if_instr_r;
  assign PCPlusFour  = if_pc4_r;
  assign IF_ID_Valid = if_valid_r;
  assign PC_out      = pc_r;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage. Memory returns Addr|0x2000_0000.
module tb_instruction_fetch_stage;

  logic        Clock;
  logic        Reset;
  logic        PCSel;
  logic [31:0] BranchPC;
  logic        Stall_PC;
  logic        Stall_ID;
  logic [31:0] Instruction;
  logic [31:0] PCPlusFour;
  logic        IF_ID_Valid;
  logic [31:0] PC_out;

  int n_cmp;
  int n_err;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .PCSel       (PCSel),
    .BranchPC    (BranchPC),
    .Stall_PC    (Stall_PC),
    .Stall_ID    (Stall_ID),
    .imem        (bus),
    .Instruction (Instruction),
    .PCPlusFour  (PCPlusFour),
    .IF_ID_Valid (IF_ID_Valid),
    .PC_out      (PC_out)
  );

  assign bus.IMem_Data = bus.IMem_Addr | 32'h2000_0000;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task tick;
    @(posedge Clock);
    #1;
  endtask

  task test_reset;
    Reset = 1'b0; PCSel = 1'b0; BranchPC = 32'h0; Stall_PC = 1'b0; Stall_ID = 1'b0;
    bus.IMem_Ready = 1'b1;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_err++; $display("FAIL rst_req0: got %b want 0", bus.IMem_Req); end
    tick;
    tick;
    n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.IMem_Req); end
    n_cmp++; if (Instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", Instruction); end
    n_cmp++; if (PCPlusFour !== 32'h0) begin n_err++; $display("FAIL rst_pc4: got %h want 0", PCPlusFour); end
    n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", IF_ID_Valid); end
    n_cmp++; if (PC_out !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", PC_out); end
    Reset = 1'b1;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", bus.IMem_Req); end
    n_cmp++; if (bus.IMem_Addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", bus.IMem_Addr); end
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0000) begin n_err++; $display("FAIL first_instr: got %h want 20000000", Instruction); end
    n_cmp++; if (PCPlusFour !== 32'h4) begin n_err++; $display("FAIL first_pc4: got %h want 4", PCPlusFour); end
    n_cmp++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", IF_ID_Valid); end
    n_cmp++; if (bus.IMem_Addr !== 32'h4) begin n_err++; $display("FAIL addr4: got %h want 4", bus.IMem_Addr); end
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0004) begin n_err++; $display("FAIL instr4: got %h want 20000004", Instruction); end
    n_cmp++; if (bus.IMem_Addr !== 32'h8) begin n_err++; $display("FAIL addr8: got %h want 8", bus.IMem_Addr); end
  endtask

  task test_mem_wait;
    bus.IMem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.IMem_Addr !== 32'h8 || bus.IMem_Req !== 1'b1) begin n_err++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want req=1 addr=8", i, bus.IMem_Req, bus.IMem_Addr); end
      tick;
      n_cmp++; if (IF_ID_Valid !== 1'b0 || Instruction !== 32'h0) begin n_err++; $display("FAIL wait_bubble[%0d]: got valid=%b instr=%h want 0/0", i, IF_ID_Valid, Instruction); end
    end
    bus.IMem_Ready = 1'b1;
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0008 || PCPlusFour !== 32'hC || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL wait_load: got %h/%h/%b want 20000008/c/1", Instruction, PCPlusFour, IF_ID_Valid); end
  endtask

  task test_hold;
    tick;
    n_cmp++; if (bus.IMem_Addr !== 32'h10) begin n_err++; $display("FAIL hold_pre_addr: got %h want 10", bus.IMem_Addr); end
    Stall_ID = 1'b1;
    tick;
    n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", bus.IMem_Req); end
    n_cmp++; if (Instruction !== 32'h2000_000C || PCPlusFour !== 32'h10 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL hold_ifid: got %h/%h/%b want 2000000c/10/1", Instruction, PCPlusFour, IF_ID_Valid); end
    tick;
    n_cmp++; if (bus.IMem_Req !== 1'b0 || Instruction !== 32'h2000_000C) begin n_err++; $display("FAIL hold_keep: got req=%b instr=%h want 0/2000000c", bus.IMem_Req, Instruction); end
    Stall_ID = 1'b0;
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0010 || PCPlusFour !== 32'h14 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL hold_release: got %h/%h/%b want 20000010/14/1", Instruction, PCPlusFour, IF_ID_Valid); end
    n_cmp++; if (bus.IMem_Addr !== 32'h14 || bus.IMem_Req !== 1'b1) begin n_err++; $display("FAIL hold_next_addr: got req=%b addr=%h want 1/14", bus.IMem_Req, bus.IMem_Addr); end
  endtask

  task test_stall_pc;
    Stall_PC = 1'b1;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_err++; $display("FAIL stallpc_req: got %b want 0", bus.IMem_Req); end
    tick;
    n_cmp++; if (IF_ID_Valid !== 1'b0 || PC_out !== 32'h14) begin n_err++; $display("FAIL stallpc_bubble: got valid=%b pc=%h want 0/14", IF_ID_Valid, PC_out); end
    Stall_PC = 1'b0;
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0014 || IF_ID_Valid !== 1'b1 || bus.IMem_Addr !== 32'h18) begin n_err++; $display("FAIL stallpc_resume: got %h/%b/%h want 20000014/1/18", Instruction, IF_ID_Valid, bus.IMem_Addr); end
  endtask

  task test_redirect;
    PCSel = 1'b1; BranchPC = 32'h0000_0043;
    tick;
    PCSel = 1'b0;
    n_cmp++; if (Instruction !== 32'h0 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %h/%b want 0/0", Instruction, IF_ID_Valid); end
    n_cmp++; if (bus.IMem_Addr !== 32'h40) begin n_err++; $display("FAIL redir_addr: got %h want 40", bus.IMem_Addr); end
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0040 || PCPlusFour !== 32'h44 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL redir_target: got %h/%h/%b want 20000040/44/1", Instruction, PCPlusFour, IF_ID_Valid); end
  endtask

  task test_redirect_wait;
    PCSel = 1'b1; BranchPC = 32'h0000_001C;
    tick;
    PCSel = 1'b0;
    tick;
    n_cmp++; if (bus.IMem_Addr !== 32'h20 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL rw_setup: got addr=%h valid=%b want 20/1", bus.IMem_Addr, IF_ID_Valid); end
    bus.IMem_Ready = 1'b0; PCSel = 1'b1; BranchPC = 32'h0000_0080;
    tick;
    PCSel = 1'b0;
    n_cmp++; if (bus.IMem_Addr !== 32'h20 || bus.IMem_Req !== 1'b1 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rw_disc1: got req=%b addr=%h valid=%b want 1/20/0", bus.IMem_Req, bus.IMem_Addr, IF_ID_Valid); end
    Stall_PC = 1'b1;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b1) begin n_err++; $display("FAIL rw_stallpc_req: got %b want 1", bus.IMem_Req); end
    tick;
    Stall_PC = 1'b0;
    n_cmp++; if (bus.IMem_Addr !== 32'h20 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rw_disc2: got addr=%h valid=%b want 20/0", bus.IMem_Addr, IF_ID_Valid); end
    bus.IMem_Ready = 1'b1;
    tick;
    n_cmp++; if (bus.IMem_Addr !== 32'h80 || IF_ID_Valid !== 1'b0 || Instruction !== 32'h0) begin n_err++; $display("FAIL rw_dropped: got addr=%h valid=%b instr=%h want 80/0/0", bus.IMem_Addr, IF_ID_Valid, Instruction); end
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0080 || PCPlusFour !== 32'h84 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL rw_target: got %h/%h/%b want 20000080/84/1", Instruction, PCPlusFour, IF_ID_Valid); end
  endtask

  task test_stall_pc_outstanding;
    bus.IMem_Ready = 1'b0;
    tick;
    Stall_PC = 1'b1;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b1 || bus.IMem_Addr !== 32'h84) begin n_err++; $display("FAIL spo_keep_req: got req=%b addr=%h want 1/84", bus.IMem_Req, bus.IMem_Addr); end
    bus.IMem_Ready = 1'b1;
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0084 || PCPlusFour !== 32'h88) begin n_err++; $display("FAIL spo_complete: got %h/%h want 20000084/88", Instruction, PCPlusFour); end
    n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_err++; $display("FAIL spo_suppress: got %b want 0", bus.IMem_Req); end
    tick;
    n_cmp++; if (PC_out !== 32'h88 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL spo_held: got pc=%h valid=%b want 88/0", PC_out, IF_ID_Valid); end
    Stall_PC = 1'b0;
  endtask

  task test_wrap_and_reset;
    tick;
    PCSel = 1'b1; BranchPC = 32'hFFFF_FFFC;
    tick;
    PCSel = 1'b0;
    n_cmp++; if (bus.IMem_Addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want fffffffc", bus.IMem_Addr); end
    tick;
    n_cmp++; if (Instruction !== 32'hFFFF_FFFC || PCPlusFour !== 32'h0 || bus.IMem_Addr !== 32'h0) begin n_err++; $display("FAIL wrap: got instr=%h pc4=%h addr=%h want fffffffc/0/0", Instruction, PCPlusFour, bus.IMem_Addr); end
    tick;
    bus.IMem_Ready = 1'b0;
    tick;
    n_cmp++; if (bus.IMem_Req !== 1'b1 || bus.IMem_Addr !== 32'h4) begin n_err++; $display("FAIL mid_pending: got req=%b addr=%h want 1/4", bus.IMem_Req, bus.IMem_Addr); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req: got %b want 0", bus.IMem_Req); end
    bus.IMem_Ready = 1'b1;
    tick;
    n_cmp++; if (PC_out !== 32'h0 || IF_ID_Valid !== 1'b0 || Instruction !== 32'h0) begin n_err++; $display("FAIL mid_rst_state: got pc=%h valid=%b instr=%h want 0/0/0", PC_out, IF_ID_Valid, Instruction); end
    Reset = 1'b1; bus.IMem_Ready = 1'b0;
    #1;
    n_cmp++; if (bus.IMem_Req !== 1'b1 || bus.IMem_Addr !== 32'h0) begin n_err++; $display("FAIL restart_req: got req=%b addr=%h want 1/0", bus.IMem_Req, bus.IMem_Addr); end
    bus.IMem_Ready = 1'b1;
    tick;
    n_cmp++; if (Instruction !== 32'h2000_0000 || PCPlusFour !== 32'h4 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL restart_fetch: got %h/%h/%b want 20000000/4/1", Instruction, PCPlusFour, IF_ID_Valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_mem_wait;
    test_hold;
    test_stall_pc;
    test_redirect;
    test_redirect_wait;
    test_stall_pc_outstanding;
    test_wrap_and_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
